// File: rtl/channel_accum_pkg.sv
// Shared types, widths and helpers for the per-channel accumulator.
package channel_accum_pkg;

`include "num_data.v"

   localparam int unsigned DATA_LEN = `DATA_LEN;
   localparam int unsigned PHASE_W  = `PHASE_W;
   localparam int unsigned ACT_MAX  = `ACT_MAX;

   // Outcome of one cycle of the phase check.
   typedef enum logic [1:0] {
      PhIdle,
      PhMatch,
      PhRestart,
      PhReject
   } phase_evt_e;

   function automatic phase_evt_e classify_phase(input logic accept,
                                                 input logic [PHASE_W-1:0] phase,
                                                 input logic [PHASE_W-1:0] expected);
      phase_evt_e evt;
      if (!accept) begin
         evt = PhIdle;
      end else if (phase == expected) begin
         evt = PhMatch;
      end else if (phase == '0) begin
         evt = PhRestart;
      end else begin
         evt = PhReject;
      end
      return evt;
   endfunction

endpackage

// File: rtl/channel_accum_relu.sv
// Combinational ReLU plus upper clamp from a signed accumulator to an activation word.
module relu_sat
   import channel_accum_pkg::*;
#(
   parameter int unsigned ACC_W = DATA_LEN + 4,
   parameter int unsigned OUT_W = DATA_LEN
) (
   input  logic signed [ACC_W-1:0] sum,
   output logic        [OUT_W-1:0] act
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);

   always_comb begin
      act = sum[OUT_W-1:0];
      if (sum[ACC_W-1]) begin
         act = '0;
      end else if (sum > SAT_MAX) begin
         act = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/num_data.v
// Shared numeric format for the layer datapath: activation width and derived constants.
`ifndef NUM_DATA_V
`define NUM_DATA_V

`define DATA_LEN 16
`define PHASE_W 3
`define ACT_MAX ((1 << (`DATA_LEN - 1)) - 1)

`endif

// File: rtl/channel_accum.sv
// Sums NPHASE partial dot products for one output channel, adds bias, applies ReLU/saturation
// and holds the activation in a one-entry valid/ready output register.
module channel_accum
   import channel_accum_pkg::*;
#(
   parameter int unsigned NPHASE = 6,
   parameter int unsigned ACC_W  = DATA_LEN + 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic        [PHASE_W-1:0]  phase,
   input  logic signed [DATA_LEN-1:0] d,
   input  logic signed [DATA_LEN-1:0] bias,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic        [DATA_LEN-1:0] q,
   output logic                       seq_err,
   output logic                       ovf_err
);

   localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NPHASE - 1);

   logic                       in_valid_d;
   logic                       accept;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [ACC_W-1:0]    d_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    sum;
   logic        [PHASE_W-1:0]  exp_ph;
   logic        [PHASE_W-1:0]  exp_next;
   logic                       seq_set;
   logic                       done;
   logic                       s2_valid;
   logic        [DATA_LEN-1:0] act;
   phase_evt_e                 evt;

   assign d_ext    = {{(ACC_W-DATA_LEN){d[DATA_LEN-1]}}, d};
   assign bias_ext = {{(ACC_W-DATA_LEN){bias[DATA_LEN-1]}}, bias};

   // A held in_valid level counts once: only its rising edge carries a partial.
   assign accept = in_valid & ~in_valid_d;
   assign evt    = classify_phase(accept, phase, exp_ph);

   always_comb begin
      acc_next = acc;
      exp_next = exp_ph;
      seq_set  = 1'b0;
      done     = 1'b0;
      unique case (evt)
         PhMatch: begin
            if (exp_ph == LAST_PH) begin
               done     = 1'b1;
               acc_next = '0;
               exp_next = '0;
            end else begin
               acc_next = acc + d_ext;
               exp_next = exp_ph + 1'b1;
            end
         end
         PhRestart: begin
            seq_set  = 1'b1;
            acc_next = d_ext;
            exp_next = PHASE_W'(1);
         end
         PhReject: begin
            seq_set = 1'b1;
         end
         default: ;
      endcase
   end

   relu_sat #(
      .ACC_W(ACC_W),
      .OUT_W(DATA_LEN)
   ) u_relu_sat (
      .sum(sum),
      .act(act)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         in_valid_d <= 1'b0;
         acc        <= '0;
         exp_ph     <= '0;
         sum        <= '0;
         s2_valid   <= 1'b0;
         out_valid  <= 1'b0;
         q          <= '0;
         seq_err    <= 1'b0;
         ovf_err    <= 1'b0;
      end else begin
         in_valid_d <= in_valid;
         acc        <= acc_next;
         exp_ph     <= exp_next;
         s2_valid   <= done;
         if (done) begin
            sum <= acc + d_ext + bias_ext;
         end
         if (seq_set) begin
            seq_err <= 1'b1;
         end
         // A full register with no transfer this cycle cannot take the new result.
         if (s2_valid) begin
            if (out_valid && !out_ready) begin
               ovf_err <= 1'b1;
            end else begin
               q         <= act;
               out_valid <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
